vsng_seq: RTL and testbench
===========================

Name: vsng_seq

Overview:
- Variable-precision stochastic number generator (SNG). It converts a TW-bit binary value into a unipolar bitstream whose length is set by a run-time precision.
- It uses a bit-reversed (van der Corput) counter compared against the top `prec` bits of the operand. Every power-of-two prefix of the stream is therefore an accurate lower-precision encoding, which supports early termination.
- It is the source end of the bitstream path: it feeds the Z input of the downstream stochastic-to-binary counter.
- It has a valid/ready handshake on both the operand side and the stream side, plus an abort for early termination.

Parameters:
- TW, 8: binary operand width; also the maximum precision. Maximum stream length is 2^TW.
- PW, $clog2(TW+1): width of the precision port.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  operand/precision offer.
- in_ready  out  1  block can accept an operand.
- B  in  TW  binary operand (unsigned fraction B/2^TW).
- prec  in  PW  stream precision p. Stream length N = 2^p.
- abort  in  1  early-termination request.
- z_valid  out  1  Z carries a valid stream bit.
- z_ready  in  1  consumer accepts the bit.
- Z  out  1  stream bit.
- z_last  out  1  current bit is index N-1.
- ones_cnt  out  TW+1  count of 1s transferred in the current/last stream.

Behaviour:
- States: IDLE, RUN. On reset:
  - state=IDLE, in_ready=1, z_valid=0, Z=0, z_last=0.
  - ones_cnt=0; internal counter k=0; B_q=0; p_q=TW.
- Precision clamp: prec==0 or prec>TW is captured as p_q=TW. Otherwise p_q=prec.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture B_q=B and p_q, set k=0, clear ones_cnt, go to RUN.
  - z_valid rises the next cycle. Latency from accept to first bit is 1 cycle.
- RUN:
  - in_ready=0 and z_valid=1.
  - Let T = B_q[TW-1 -: p_q] (the top p_q bits) and R = bit-reverse of k[p_q-1:0] over p_q bits.
  - Z = (T > R), unsigned compare, p_q bits wide.
  - z_last = (k == 2^p_q - 1).
  - Z and z_last are pure functions of registers. They must stay stable while z_valid & !z_ready.
- Transfer: occurs when z_valid & z_ready.
  - k increments.
  - ones_cnt += Z. It saturates at neither end: its maximum value is 2^TW - 1, which fits in TW+1 bits.
  - A transfer with z_last set returns to IDLE. In the next cycle z_valid=0 and in_ready=1, and k resets to 0.
  - There is no back-to-back accept in the same cycle as the last transfer.
- Count property: over a full stream, total ones = T exactly. For any prefix of length 2^j (j ≤ p_q), the ones count equals floor(T / 2^(p_q-j)) or that value +1.
- k width is TW+1 bits so that N = 2^TW does not alias. The bit-reverse uses only the low p_q bits.
- Abort:
  - Abort in RUN → IDLE next cycle, z_valid=0.
  - If abort coincides with a transfer, the transfer completes (ones_cnt updated) and then the block goes to IDLE.
  - Abort in IDLE is ignored. If abort and in_valid are both high in IDLE, the accept wins.
- ones_cnt holds its value in IDLE until the next accept. This covers normal completion and abort.
- Inputs B/prec are sampled only at accept. Changes during RUN have no effect.
- rst in any state, including mid-stream, returns all outputs to their reset values on the next edge and discards the stream.

Test Plan:
- TW=8, B=8'hA0, prec=3, z_ready=1:
  - Z sequence k0..7 = 1,1,1,0,1,0,1,0.
  - z_last only on the 8th bit; ones_cnt=5.
  - in_ready=1 the cycle after the last bit; first z_valid exactly 1 cycle after accept.
- Edge operands:
  - B=8'h00, prec=8 → 256 zeros, ones_cnt=0.
  - B=8'hFF, prec=8 → 255 ones then a final 0, ones_cnt=255.
  - B=8'h80, prec=1 → Z=1,0, ones_cnt=1.
  - prec=0 behaves as prec=8.
- Backpressure: B=8'hA0, prec=3, z_ready low for 3 cycles at k=2 → Z=1 and z_valid=1 held stable, k not advanced. The final sequence and ones_cnt=5 are unchanged.
- Abort:
  - Abort asserted with z_ready=1 at k=3 (B=8'hA0, prec=3) → the k=3 bit (0) transfers, ones_cnt=3, IDLE next cycle.
  - Abort with z_ready=0 → no transfer, ones_cnt=3 after k=0..2 (1,1,1), IDLE next cycle.
- Prefix accuracy: random B, prec=8 → at each prefix length 2^j the ones count is within {floor(B/2^(8-j)), +1}, and the full count equals B.
- Reset mid-stream: rst at k=4 → next cycle z_valid=0, in_ready=1, ones_cnt=0. A new accept then starts at k=0 and produces the correct sequence.

Source files
------------

// File: rtl/vsng_seq_if.sv
// rtl/vsng_seq_if.sv - operand/stream handshake bundle for the variable-precision SNG
interface vsng_seq_if #(
    parameter int TW = 8,
    parameter int PW = $clog2(TW + 1)
) ();
    // Operand side
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] B;
    logic [PW-1:0] prec;
    logic          abort;
    // Stream side
    logic          z_valid;
    logic          z_ready;
    logic          Z;
    logic          z_last;
    logic [TW:0]   ones_cnt;

    // The generator itself
    modport slave (
        input  in_valid, B, prec, abort, z_ready,
        output in_ready, z_valid, Z, z_last, ones_cnt
    );

    // Whatever supplies operands and consumes the stream
    modport master (
        output in_valid, B, prec, abort, z_ready,
        input  in_ready, z_valid, Z, z_last, ones_cnt
    );
endinterface

// File: rtl/vsng_seq.sv
// rtl/vsng_seq.sv - variable-precision stochastic number generator (bit-reversed counter)
module vsng_seq #(
    parameter int TW = 8,
    parameter int PW = $clog2(TW + 1)
) (
    input logic       clk,
    input logic       rst,
    vsng_seq_if.slave bus
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PW-1:0] TW_P    = PW'(TW);
    localparam logic [TW:0]   K_ONE   = (TW+1)'(1);
    localparam logic [TW:0]   ONES_Z  = '0;

    state_t        state_q, state_d;
    // k is TW+1 bits so that a full 2^TW stream does not alias back to 0
    logic [TW:0]   k_q, k_d;
    logic [TW-1:0] b_q, b_d;
    logic [PW-1:0] p_q, p_d;
    logic [TW:0]   ones_q, ones_d;

    logic [PW-1:0] prec_clamped;
    logic [PW-1:0] shamt;
    logic [TW-1:0] t_val;
    logic [TW-1:0] rev_full;
    logic [TW-1:0] r_val;
    logic [TW:0]   last_k;
    logic          z_bit;
    logic          last_bit;
    logic          running;
    logic          accept;
    logic          xfer;

    // Out-of-range precision (0 or above TW) means full precision
    always_comb begin
        prec_clamped = bus.prec;
        if ((bus.prec == '0) || (bus.prec > TW_P)) begin
            prec_clamped = TW_P;
        end
    end

    // Comparator: top p_q bits of the operand against the p_q-bit reversed counter.
    // Reversing all TW bits and shifting right by TW-p_q leaves exactly the
    // reverse of k[p_q-1:0]; the higher k bits fall off the bottom.
    always_comb begin
        rev_full = '0;
        for (int i = 0; i < TW; i++) begin
            rev_full[i] = k_q[TW-1-i];
        end
        shamt    = TW_P - p_q;
        t_val    = b_q >> shamt;
        r_val    = rev_full >> shamt;
        last_k   = (K_ONE << p_q) - K_ONE;
        z_bit    = (t_val > r_val);
        last_bit = (k_q == last_k);
    end

    assign running       = (state_q == RUN);
    assign bus.in_ready  = !running;
    assign bus.z_valid   = running;
    assign bus.Z         = running & z_bit;
    assign bus.z_last    = running & last_bit;
    assign bus.ones_cnt  = ones_q;

    assign accept = !running & bus.in_valid;
    assign xfer   = running & bus.z_ready;

    // Next-state: accept captures operand/precision, transfers advance k and the
    // ones count, last bit or abort drops back to IDLE with k rearmed at 0
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        b_d     = b_q;
        p_d     = p_q;
        ones_d  = ones_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    b_d     = bus.B;
                    p_d     = prec_clamped;
                    k_d     = '0;
                    ones_d  = ONES_Z;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    k_d    = k_q + K_ONE;
                    ones_d = ones_q + {{TW{1'b0}}, z_bit};
                end
                if ((xfer && last_bit) || bus.abort) begin
                    k_d     = '0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; reset discards any stream in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            b_q     <= '0;
            p_q     <= TW_P;
            ones_q  <= ONES_Z;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            b_q     <= b_d;
            p_q     <= p_d;
            ones_q  <= ones_d;
        end
    end
endmodule

// File: tb/tb_vsng_seq.sv
// tb/tb_vsng_seq.sv - self-checking bench for vsng_seq
module tb_vsng_seq;
    localparam int TW = 8;
    localparam int PW = $clog2(TW + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    vsng_seq_if #(.TW(TW), .PW(PW)) bus ();

    vsng_seq #(.TW(TW), .PW(PW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct {
        logic [7:0] b;
        logic [3:0] pr;
        int         exp_ones;
        int         exp_len;
    } vec_t;

    int checks = 0;
    int errors = 0;
    bit exp_bits[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input longint act, input longint lo, input longint hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int clampp(input int pr);
        return (pr == 0 || pr > TW) ? TW : pr;
    endfunction

    // van der Corput order built by doubling: each level lists evens then odds
    task automatic build_model(input int b, input int p);
        int order[$];
        int nxt[$];
        int t;
        order = {0};
        for (int l = 0; l < p; l++) begin
            nxt = {};
            foreach (order[i]) nxt.push_back(2 * order[i]);
            foreach (order[i]) nxt.push_back(2 * order[i] + 1);
            order = nxt;
        end
        t = b / (1 << (TW - p));
        exp_bits = {};
        foreach (order[i]) exp_bits.push_back(t > order[i]);
    endtask

    task automatic accept(input logic [7:0] b, input logic [3:0] pr);
        bus.in_valid = 1'b1;
        bus.B        = b;
        bus.prec     = pr;
        tick();
        bus.in_valid = 1'b0;
        bus.B        = 8'($urandom);
        bus.prec     = 4'($urandom);
    endtask

    task automatic run_full(input logic [7:0] b, input logic [3:0] pr, input int n,
                            input bit rand_ready, input int stall_at, input int stall_len,
                            input int exp_ones, input string name);
        int p, t, idx, cyc, ones, stalled, j, lo;
        bit rdy;
        logic [3:0] act_v, exp_v;
        p = clampp(int'(pr));
        t = int'(b) / (1 << (TW - p));
        build_model(int'(b), p);
        chk({name, " in_ready before"}, bus.in_ready, 1);
        accept(b, pr);
        idx = 0; cyc = 0; ones = 0; stalled = 0;
        while (idx < n && cyc < 4000) begin
            act_v = {bus.z_valid, bus.in_ready, bus.Z, bus.z_last};
            exp_v = {1'b1, 1'b0, exp_bits[idx], (idx == n - 1)};
            if (act_v != exp_v)
                $display("  %s k=%0d {z_valid,in_ready,Z,z_last}", name, idx);
            chk({name, " bit"}, act_v, exp_v);
            if (idx == stall_at && stalled < stall_len) begin
                rdy = 1'b0;
                stalled++;
            end else if (rand_ready) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            bus.z_ready = rdy;
            tick();
            cyc++;
            if (rdy) begin
                ones += exp_bits[idx];
                idx++;
                if ((idx & (idx - 1)) == 0) begin
                    j  = $clog2(idx);
                    lo = t / (1 << (p - j));
                    chk_range({name, " prefix"}, bus.ones_cnt, lo, lo + 1);
                    chk({name, " prefix exact"}, bus.ones_cnt, ones);
                end
            end
        end
        bus.z_ready = 1'b0;
        if (idx < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got %0d bits expected %0d", name, idx, n);
        end
        chk({name, " z_valid after"}, bus.z_valid, 0);
        chk({name, " in_ready after"}, bus.in_ready, 1);
        chk({name, " ones_cnt"}, bus.ones_cnt, exp_ones);
    endtask

    vec_t vecs[10];

    initial begin
        int rb, rp, k;
        vecs[0] = '{8'hA0, 4'd3,  5,   8};
        vecs[1] = '{8'h00, 4'd8,  0,   256};
        vecs[2] = '{8'hFF, 4'd8,  255, 256};
        vecs[3] = '{8'h80, 4'd1,  1,   2};
        vecs[4] = '{8'hA0, 4'd0,  160, 256};
        vecs[5] = '{8'h3C, 4'd12, 60,  256};
        vecs[6] = '{8'h5A, 4'd4,  5,   16};
        vecs[7] = '{8'h01, 4'd8,  1,   256};
        vecs[8] = '{8'hFF, 4'd1,  1,   2};
        vecs[9] = '{8'hC3, 4'd2,  3,   4};

        bus.in_valid = 1'b0;
        bus.B        = '0;
        bus.prec     = '0;
        bus.abort    = 1'b0;
        bus.z_ready  = 1'b0;
        rst          = 1'b1;
        tick();
        tick();
        chk("reset in_ready", bus.in_ready, 1);
        chk("reset z_valid", bus.z_valid, 0);
        chk("reset Z", bus.Z, 0);
        chk("reset z_last", bus.z_last, 0);
        chk("reset ones_cnt", bus.ones_cnt, 0);
        rst = 1'b0;
        tick();

        // Table of full streams, consumer always ready
        foreach (vecs[i])
            run_full(vecs[i].b, vecs[i].pr, vecs[i].exp_len, 1'b0, -1, 0, vecs[i].exp_ones,
                     $sformatf("vec%0d", i));

        // Backpressure at k=2 for three cycles
        run_full(8'hA0, 4'd3, 8, 1'b0, 2, 3, 5, "stall");

        // Randomized streams with random backpressure
        for (int r = 0; r < 8; r++) begin
            rb = int'($urandom_range(0, 255));
            rp = (r < 5) ? 8 : int'($urandom_range(0, 15));
            run_full(8'(rb), 4'(rp), 1 << clampp(rp), 1'b1, -1, 0,
                     rb / (1 << (TW - clampp(rp))), $sformatf("rand%0d", r));
        end

        // Abort coinciding with a transfer at k=3
        accept(8'hA0, 4'd3);
        bus.z_ready = 1'b1;
        tick(); tick(); tick();
        chk("abortx k3 Z", bus.Z, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort   = 1'b0;
        bus.z_ready = 1'b0;
        chk("abortx z_valid", bus.z_valid, 0);
        chk("abortx in_ready", bus.in_ready, 1);
        chk("abortx ones_cnt", bus.ones_cnt, 3);
        tick();
        chk("abortx ones hold", bus.ones_cnt, 3);

        // Abort without a transfer at k=3
        accept(8'hA0, 4'd3);
        bus.z_ready = 1'b1;
        tick(); tick(); tick();
        bus.z_ready = 1'b0;
        bus.abort   = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abortn z_valid", bus.z_valid, 0);
        chk("abortn ones_cnt", bus.ones_cnt, 3);

        // Abort alone in IDLE is ignored
        bus.abort = 1'b1;
        tick();
        chk("idle abort in_ready", bus.in_ready, 1);
        chk("idle abort z_valid", bus.z_valid, 0);
        chk("idle abort ones hold", bus.ones_cnt, 3);

        // Abort together with in_valid in IDLE: accept wins
        accept(8'h80, 4'd1);
        bus.abort = 1'b0;
        chk("abort+accept z_valid", bus.z_valid, 1);
        chk("abort+accept Z", bus.Z, 1);
        chk("abort+accept ones clr", bus.ones_cnt, 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abort+accept idle", bus.in_ready, 1);

        // Reset mid-stream at k=4, then a clean stream
        accept(8'hA0, 4'd3);
        bus.z_ready = 1'b1;
        k = 0;
        while (k < 4) begin
            tick();
            k++;
        end
        bus.z_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst z_valid", bus.z_valid, 0);
        chk("midrst in_ready", bus.in_ready, 1);
        chk("midrst ones_cnt", bus.ones_cnt, 0);
        chk("midrst z_last", bus.z_last, 0);
        run_full(8'hA0, 4'd3, 8, 1'b0, -1, 0, 5, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
